// File: rtl/rr_mux_4to1_16b.sv
// rr_mux_4to1_16b
// Merges words from four source channels onto one registered output stream.
// Channels are granted in round-robin order. Each accepted word is tagged with
// the 2-bit index of the channel it came from.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data0-3 per-channel data
//   in_valid   bit i: channel i offers a word
//   in_ready   bit i: channel i's word is accepted this cycle (at most one bit high)
//   out_data   registered merged data
//   out_sel    registered source index of out_data
//   out_valid  out_data/out_sel hold a word
//   out_ready  consumer accepts the held word this cycle
//   rr_ptr     channel that currently has the highest priority (debug)
module rr_mux_4to1_16b #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       rr_ptr
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;

  logic             can_load;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // The slot can take a word if it is empty or is being drained this cycle.
  assign can_load = !out_valid_q || out_ready;

  // Round-robin scan starting at rr_ptr; 2-bit addition wraps naturally.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    scan_idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!grant_valid && in_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign xfer = grant_valid && can_load;

  always_comb begin
    in_ready = 4'b0000;
    if (xfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    grant_data = in_data0;
    unique case (grant_idx)
      2'd0: grant_data = in_data0;
      2'd1: grant_data = in_data1;
      2'd2: grant_data = in_data2;
      2'd3: grant_data = in_data3;
      default: grant_data = in_data0;
    endcase
  end

  // Load and drain may happen on the same edge, giving one word per cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      rr_ptr_d    = grant_idx + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= 2'd0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_rr_mux_4to1_16b.sv
// Self-checking bench for rr_mux_4to1_16b: directed literal checks followed by
// a randomized soak compared every cycle against a behavioural model.
module tb_rr_mux_4to1_16b;

  logic        clk;
  logic        rst_n;
  logic [15:0] d0, d1, d2, d3;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  rr_ptr;

  int total = 0;
  int bad   = 0;

  rr_mux_4to1_16b #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data0 (d0),
    .in_data1 (d1),
    .in_data2 (d2),
    .in_data3 (d3),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rr_ptr   (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  typedef logic [15:0] word_q_t [$];
  word_q_t     sent [4];
  logic        src_v [4];
  logic [15:0] src_d [4];
  int          wait_cnt [4];
  bit          m_valid;
  int          m_data;
  int          m_sel;
  int          m_ptr;

  function automatic int model_grant();
    int c;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (src_v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_sel   = 0;
    m_ptr   = 0;
    for (int i = 0; i < 4; i++) begin
      src_v[i] = 1'b0;
      src_d[i] = 16'h0;
      wait_cnt[i] = 0;
      sent[i].delete();
    end
  endtask

  task automatic apply_src();
    in_valid = {src_v[3], src_v[2], src_v[1], src_v[0]};
    d0 = src_d[0];
    d1 = src_d[1];
    d2 = src_d[2];
    d3 = src_d[3];
  endtask

  // Compare DUT against model, then advance the model across the coming edge.
  task automatic compare_and_step();
    int g;
    int exp_ready;
    bit load_ok;
    int ch;
    g = model_grant();
    load_ok = !m_valid || out_ready;
    exp_ready = (g >= 0 && load_ok) ? (1 << g) : 0;
    chk("soak_in_ready", int'(in_ready), exp_ready);
    chk("soak_onehot0", int'($onehot0(in_ready)), 1);
    chk("soak_out_valid", int'(out_valid), int'(m_valid));
    chk("soak_out_data", int'(out_data), m_data);
    chk("soak_out_sel", int'(out_sel), m_sel);
    chk("soak_rr_ptr", int'(rr_ptr), m_ptr);

    if (m_valid && out_ready) begin
      ch = int'(out_sel);
      if (sent[ch].size() == 0) begin
        chk("soak_dup", int'(out_data), -1);
      end else begin
        chk("soak_order", int'(out_data), int'(sent[ch].pop_front()));
      end
    end

    if (g >= 0 && load_ok) begin
      for (int j = 0; j < 4; j++) begin
        if (j == g) begin
          wait_cnt[j] = 0;
        end else if (src_v[j]) begin
          wait_cnt[j]++;
          chk("soak_starve", int'(wait_cnt[j] <= 3), 1);
        end
      end
      m_valid = 1;
      m_data  = int'(src_d[g]);
      m_sel   = g;
      m_ptr   = (g + 1) % 4;
      src_v[g] = 1'b0;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    chk("rst_rr_ptr", int'(rr_ptr), 0);
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rot_data [4];
    rot_data[0] = 16'h1111;
    rot_data[1] = 16'h2222;
    rot_data[2] = 16'h3333;
    rot_data[3] = 16'h4444;

    rst_n = 1'b0;
    in_valid = 4'b0000;
    out_ready = 1'b0;
    d0 = 16'h0; d1 = 16'h0; d2 = 16'h0; d3 = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_out_data", int'(out_data), 0);
    chk("init_rr_ptr", int'(rr_ptr), 0);
    chk("init_in_ready", int'(in_ready), 0);

    // Single word from channel 2
    @(negedge clk);
    in_valid = 4'b0100; d2 = 16'hBEEF; out_ready = 1'b1;
    #1 chk("single_in_ready", int'(in_ready), 4'b0100);
    @(negedge clk);
    chk("single_out_valid", int'(out_valid), 1);
    chk("single_out_data", int'(out_data), 16'hBEEF);
    chk("single_out_sel", int'(out_sel), 2);
    chk("single_rr_ptr", int'(rr_ptr), 3);
    in_valid = 4'b0000;

    // Asynchronous reset while a word is held
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_out_sel", int'(out_sel), 0);
    chk("arst_rr_ptr", int'(rr_ptr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin rotation with all channels valid
    d0 = rot_data[0]; d1 = rot_data[1]; d2 = rot_data[2]; d3 = rot_data[3];
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rot_in_ready", int'(in_ready), 1 << (k % 4));
      @(negedge clk);
      chk("rot_out_valid", int'(out_valid), 1);
      chk("rot_out_sel", int'(out_sel), k % 4);
      chk("rot_out_data", int'(out_data), int'(rot_data[k % 4]));
    end
    in_valid = 4'b0000;

    // Pointer wrap and skip: bring rr_ptr to 3 then offer channels 0 and 1
    @(negedge clk);
    in_valid = 4'b0100; d2 = 16'h0C0C;
    @(negedge clk);
    chk("wrap_pre_ptr", int'(rr_ptr), 3);
    in_valid = 4'b0011; d0 = 16'h0A0A; d1 = 16'h0B0B;
    #1 chk("wrap_in_ready0", int'(in_ready), 4'b0001);
    @(negedge clk);
    chk("wrap_out_sel0", int'(out_sel), 0);
    chk("wrap_rr_ptr1", int'(rr_ptr), 1);
    #1 chk("wrap_in_ready1", int'(in_ready), 4'b0010);
    @(negedge clk);
    chk("wrap_out_sel1", int'(out_sel), 1);
    chk("wrap_out_data1", int'(out_data), 16'h0B0B);
    chk("wrap_rr_ptr2", int'(rr_ptr), 2);
    in_valid = 4'b0000;

    // Backpressure
    @(negedge clk);
    chk("bp_drained", int'(out_valid), 0);
    in_valid = 4'b0010; d1 = 16'hAAAA; out_ready = 1'b0;
    @(negedge clk);
    chk("bp_load_valid", int'(out_valid), 1);
    chk("bp_load_data", int'(out_data), 16'hAAAA);
    in_valid = 4'b1000; d3 = 16'h3333;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_data", int'(out_data), 16'hAAAA);
      chk("bp_hold_sel", int'(out_sel), 1);
      chk("bp_hold_ptr", int'(rr_ptr), 2);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", int'(in_ready), 4'b1000);
    @(negedge clk);
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_sel", int'(out_sel), 3);
    chk("bp_next_data", int'(out_data), 16'h3333);
    in_valid = 4'b0000;

    // Random soak against the model
    async_reset();
    model_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!src_v[i] && $urandom_range(0, 99) < 55) begin
          src_v[i] = 1'b1;
          src_d[i] = 16'($urandom);
          sent[i].push_back(src_d[i]);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      apply_src();
      #1 compare_and_step();
    end

    // Drain: no new words; everything offered must come out
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      apply_src();
      #1 compare_and_step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("drain_lost", sent[i].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
